// File: rtl/clint_reg_arbiter.sv
// Round-robin arbiter sharing the CLINT register port between NumReq requesters.
// One access at a time: grant (IDLE), register access (ACCESS), response pulse (RESP).
module clint_reg_arbiter #(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NumReq-1:0]                 req_i,
  input  logic [NumReq-1:0]                 we_i,
  input  logic [NumReq*AddrWidth-1:0]       addr_i,
  input  logic [NumReq*(DataWidth/8)-1:0]   be_i,
  input  logic [NumReq*DataWidth-1:0]       wdata_i,
  output logic [NumReq-1:0]                 gnt_o,
  output logic [NumReq-1:0]                 rvalid_o,
  output logic [DataWidth-1:0]              rdata_o,
  output logic                              en_o,
  output logic                              we_o,
  output logic [AddrWidth-1:0]              address_o,
  output logic [DataWidth/8-1:0]            be_o,
  output logic [DataWidth-1:0]              data_o,
  input  logic [DataWidth-1:0]              data_i
);

  localparam int unsigned BeWidth = DataWidth / 8;
  localparam int unsigned IdxW    = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        ptr_q, idx_q, win;
  logic                   any_req, found;
  logic [NumReq-1:0]      upper;
  logic                   we_q, we_sel;
  logic [AddrWidth-1:0]   addr_q, addr_sel;
  logic [BeWidth-1:0]     be_q, be_sel;
  logic [DataWidth-1:0]   wdata_q, wdata_sel, rdata_q;

  // Winner: first request at or after ptr_q, otherwise the first one below it.
  always_comb begin
    win     = '0;
    found   = 1'b0;
    any_req = |req_i;
    upper   = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      upper[i] = req_i[i] && (i >= 32'(ptr_q));
    end
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!found && upper[i]) begin
        win   = IdxW'(i);
        found = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!found && req_i[i]) begin
        win   = IdxW'(i);
        found = 1'b1;
      end
    end
  end

  // Payload mux for the winning requester.
  always_comb begin
    we_sel    = 1'b0;
    addr_sel  = '0;
    be_sel    = '0;
    wdata_sel = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (IdxW'(i) == win) begin
        we_sel    = we_i[i];
        addr_sel  = addr_i[i*AddrWidth +: AddrWidth];
        be_sel    = be_i[i*BeWidth +: BeWidth];
        wdata_sel = wdata_i[i*DataWidth +: DataWidth];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state and port outputs.
  always_comb begin
    state_d   = state_q;
    gnt_o     = '0;
    rvalid_o  = '0;
    en_o      = 1'b0;
    we_o      = 1'b0;
    address_o = '0;
    be_o      = '0;
    data_o    = '0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          for (int unsigned i = 0; i < NumReq; i++) gnt_o[i] = (IdxW'(i) == win);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        en_o      = 1'b1;
        we_o      = we_q;
        address_o = addr_q;
        be_o      = be_q;
        data_o    = wdata_q;
        state_d   = RESP;
      end
      RESP: begin
        for (int unsigned i = 0; i < NumReq; i++) rvalid_o[i] = (IdxW'(i) == idx_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant bookkeeping, latched payload and captured read data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state_q == IDLE && any_req) begin
        idx_q   <= win;
        ptr_q   <= (win == IdxW'(NumReq - 1)) ? '0 : win + IdxW'(1);
        we_q    <= we_sel;
        addr_q  <= addr_sel;
        be_q    <= be_sel;
        wdata_q <= wdata_sel;
      end
      if (state_q == ACCESS) begin
        rdata_q <= we_q ? '0 : data_i;
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule
